pll_lock_supervisor: RTL and testbench

//  Drives the PLL reset and consumes the PLL's lock output. Sits between the board

---
 rtl/pll_lock_supervisor.sv | 155 +++++++++++++++
 tb/tb_pll_lock_supervisor.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/pll_lock_supervisor.sv
// PLL reset sequencer: pulses the PLL reset, waits for a qualified lock with timeout and
// bounded retries, then releases the system reset and tracks lock-loss events.
module pll_lock_supervisor #(
    parameter int RST_PULSE_CYCLES    = 16,
    parameter int LOCK_STABLE_CYCLES  = 1024,
    parameter int LOCK_TIMEOUT_CYCLES = 50000,
    parameter int MAX_RETRIES         = 3
) (
    input  logic       i_refclk,
    input  logic       i_rst,
    input  logic       i_pll_locked,
    input  logic       i_clear_fault,
    output logic       o_pll_rst,
    output logic       o_sys_rst,
    output logic       o_locked_ok,
    output logic       o_fault,
    output logic [3:0] o_retry_count,
    output logic [7:0] o_lock_loss_count
);

    localparam int CNT_MAX_A = (RST_PULSE_CYCLES > LOCK_STABLE_CYCLES) ?
                               RST_PULSE_CYCLES : LOCK_STABLE_CYCLES;
    localparam int CNT_MAX   = (CNT_MAX_A > LOCK_TIMEOUT_CYCLES) ?
                               CNT_MAX_A : LOCK_TIMEOUT_CYCLES;
    localparam int CNT_W     = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

    // The shared counter holds "cycles remaining minus one", so each load is N-1.
    localparam logic [CNT_W-1:0] RST_LOAD     = CNT_W'(RST_PULSE_CYCLES - 1);
    localparam logic [CNT_W-1:0] STABLE_LOAD  = CNT_W'(LOCK_STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LOAD = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE      = CNT_W'(1);
    localparam logic [3:0]       RETRY_LIMIT  = 4'(MAX_RETRIES);

    typedef enum logic [2:0] {
        S_RESET_PLL,
        S_WAIT_LOCK,
        S_STABILIZE,
        S_RUN,
        S_FAULT
    } state_t;

    state_t           r_state;
    logic             r_sync1;
    logic             r_locked_s;
    logic [CNT_W-1:0] r_cnt;
    logic             r_pll_rst;
    logic             r_sys_rst;
    logic             r_locked_ok;
    logic             r_fault;
    logic [3:0]       r_retry_count;
    logic [7:0]       r_lock_loss_count;

    logic             w_cnt_zero;
    logic [3:0]       w_retry_next;

    assign w_cnt_zero   = (r_cnt == '0);
    assign w_retry_next = r_retry_count + 4'd1;

    always_ff @(posedge i_refclk) begin
        if (i_rst) begin
            r_state           <= S_RESET_PLL;
            r_sync1           <= 1'b0;
            r_locked_s        <= 1'b0;
            r_cnt             <= RST_LOAD;
            r_pll_rst         <= 1'b1;
            r_sys_rst         <= 1'b1;
            r_locked_ok       <= 1'b0;
            r_fault           <= 1'b0;
            r_retry_count     <= 4'd0;
            r_lock_loss_count <= 8'd0;
        end else begin
            r_sync1    <= i_pll_locked;
            r_locked_s <= r_sync1;
            case (r_state)
                S_RESET_PLL: begin
                    if (w_cnt_zero) begin
                        r_state   <= S_WAIT_LOCK;
                        r_cnt     <= TIMEOUT_LOAD;
                        r_pll_rst <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt - CNT_ONE;
                    end
                end
                // A lock seen on the timeout cycle takes priority over the retry.
                S_WAIT_LOCK: begin
                    if (r_locked_s) begin
                        r_state <= S_STABILIZE;
                        r_cnt   <= STABLE_LOAD;
                    end else if (w_cnt_zero) begin
                        r_retry_count <= w_retry_next;
                        r_cnt         <= RST_LOAD;
                        r_pll_rst     <= 1'b1;
                        if (w_retry_next == RETRY_LIMIT) begin
                            r_state <= S_FAULT;
                            r_fault <= 1'b1;
                        end else begin
                            r_state <= S_RESET_PLL;
                        end
                    end else begin
                        r_cnt <= r_cnt - CNT_ONE;
                    end
                end
                S_STABILIZE: begin
                    if (!r_locked_s) begin
                        r_state <= S_WAIT_LOCK;
                        r_cnt   <= TIMEOUT_LOAD;
                    end else if (w_cnt_zero) begin
                        r_state       <= S_RUN;
                        r_sys_rst     <= 1'b0;
                        r_locked_ok   <= 1'b1;
                        r_retry_count <= 4'd0;
                    end else begin
                        r_cnt <= r_cnt - CNT_ONE;
                    end
                end
                S_RUN: begin
                    if (!r_locked_s) begin
                        r_state     <= S_RESET_PLL;
                        r_cnt       <= RST_LOAD;
                        r_pll_rst   <= 1'b1;
                        r_sys_rst   <= 1'b1;
                        r_locked_ok <= 1'b0;
                        if (r_lock_loss_count != 8'hFF) begin
                            r_lock_loss_count <= r_lock_loss_count + 8'd1;
                        end
                    end
                end
                S_FAULT: begin
                    if (i_clear_fault) begin
                        r_state       <= S_RESET_PLL;
                        r_cnt         <= RST_LOAD;
                        r_fault       <= 1'b0;
                        r_retry_count <= 4'd0;
                    end
                end
                default: begin
                    r_state     <= S_RESET_PLL;
                    r_cnt       <= RST_LOAD;
                    r_pll_rst   <= 1'b1;
                    r_sys_rst   <= 1'b1;
                    r_locked_ok <= 1'b0;
                    r_fault     <= 1'b0;
                end
            endcase
        end
    end

    assign o_pll_rst         = r_pll_rst;
    assign o_sys_rst         = r_sys_rst;
    assign o_locked_ok       = r_locked_ok;
    assign o_fault           = r_fault;
    assign o_retry_count     = r_retry_count;
    assign o_lock_loss_count = r_lock_loss_count;

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// Self-checking bench for pll_lock_supervisor: vector table, directed corner sequences
// and randomized lock activity compared against a phase/elapsed-time reference model.
module tb_pll_lock_supervisor;

    localparam int RST_PULSE = 4;
    localparam int STABLE    = 8;
    localparam int TIMEOUT   = 32;
    localparam int MAXR      = 2;

    logic       clk = 1'b0;
    logic       iRst = 1'b1;
    logic       iLocked = 1'b0;
    logic       iClear = 1'b0;
    logic       oPllRst, oSysRst, oLockedOk, oFault;
    logic [3:0] oRetry;
    logic [7:0] oLoss;

    int checks = 0;
    int failures = 0;

    pll_lock_supervisor #(
        .RST_PULSE_CYCLES   (RST_PULSE),
        .LOCK_STABLE_CYCLES (STABLE),
        .LOCK_TIMEOUT_CYCLES(TIMEOUT),
        .MAX_RETRIES        (MAXR)
    ) dut (
        .i_refclk         (clk),
        .i_rst            (iRst),
        .i_pll_locked     (iLocked),
        .i_clear_fault    (iClear),
        .o_pll_rst        (oPllRst),
        .o_sys_rst        (oSysRst),
        .o_locked_ok      (oLockedOk),
        .o_fault          (oFault),
        .o_retry_count    (oRetry),
        .o_lock_loss_count(oLoss)
    );

    always #5 clk = ~clk;

    // Reference model: which phase we are in and how long we have been there.
    typedef enum {M_PULSE, M_WAIT, M_QUAL, M_RUN, M_FAULT} mphase_t;
    mphase_t mPhase = M_PULSE;
    int      mElapsed = 0;
    int      mRetries = 0;
    int      mLosses = 0;
    bit      mHist[$] = '{1'b0, 1'b0};

    task automatic modelStep(input bit r, input bit lk, input bit clr);
        bit seen;
        if (r) begin
            mPhase = M_PULSE; mElapsed = 0; mRetries = 0; mLosses = 0;
            mHist = '{1'b0, 1'b0};
        end else begin
            seen = mHist.pop_front();
            mHist.push_back(lk);
            case (mPhase)
                M_PULSE: begin
                    mElapsed++;
                    if (mElapsed == RST_PULSE) begin mPhase = M_WAIT; mElapsed = 0; end
                end
                M_WAIT: begin
                    if (seen) begin
                        mPhase = M_QUAL; mElapsed = 0;
                    end else begin
                        mElapsed++;
                        if (mElapsed == TIMEOUT) begin
                            mRetries++;
                            mPhase = (mRetries == MAXR) ? M_FAULT : M_PULSE;
                            mElapsed = 0;
                        end
                    end
                end
                M_QUAL: begin
                    if (!seen) begin
                        mPhase = M_WAIT; mElapsed = 0;
                    end else begin
                        mElapsed++;
                        if (mElapsed == STABLE) begin mPhase = M_RUN; mRetries = 0; end
                    end
                end
                M_RUN: begin
                    if (!seen) begin
                        mPhase = M_PULSE; mElapsed = 0;
                        if (mLosses < 255) mLosses++;
                    end
                end
                M_FAULT: begin
                    if (clr) begin mPhase = M_PULSE; mElapsed = 0; mRetries = 0; end
                end
            endcase
        end
    endtask

    function automatic logic [15:0] dutVec();
        return {oPllRst, oSysRst, oLockedOk, oFault, oRetry, oLoss};
    endfunction

    task automatic expectVal(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic checkOutput(input string tag);
        logic [15:0] exp;
        exp = {(mPhase == M_PULSE || mPhase == M_FAULT), (mPhase != M_RUN),
               (mPhase == M_RUN), (mPhase == M_FAULT), 4'(mRetries), 8'(mLosses)};
        expectVal(tag, int'(dutVec()), int'(exp));
    endtask

    task automatic applyStimulus(input bit r, input bit lk, input bit clr);
        iRst = r; iLocked = lk; iClear = clr;
        @(posedge clk);
        modelStep(r, lk, clr);
        #1;
        checkOutput("model");
    endtask

    task automatic doReset();
        applyStimulus(1'b1, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b0);
    endtask

    task automatic expectResetVals(input string name);
        expectVal(name, int'(dutVec()), int'(16'hC000));
    endtask

    typedef struct {
        bit rst; bit lk; bit clr; int reps;
        bit pll; bit sys; bit ok; bit flt; int retry; int loss;
    } vec_t;
    vec_t vecs[5];

    int cnt;
    int runLeft;
    bit rndLk;

    initial begin
        // Bring-up: reset, 4-cycle PLL pulse, lock 10 cycles after pll_rst falls.
        vecs[0] = '{1, 0, 0, 2,  1, 1, 0, 0, 0, 0};
        vecs[1] = '{0, 0, 0, 3,  1, 1, 0, 0, 0, 0};
        vecs[2] = '{0, 0, 0, 10, 0, 1, 0, 0, 0, 0};
        vecs[3] = '{0, 1, 0, 10, 0, 1, 0, 0, 0, 0};
        vecs[4] = '{0, 1, 0, 3,  0, 0, 1, 0, 0, 0};

        for (int v = 0; v < 5; v++) begin
            for (int k = 0; k < vecs[v].reps; k++) begin
                applyStimulus(vecs[v].rst, vecs[v].lk, vecs[v].clr);
                expectVal($sformatf("vec%0d_%0d", v, k), int'(dutVec()),
                          int'({vecs[v].pll, vecs[v].sys, vecs[v].ok, vecs[v].flt,
                                4'(vecs[v].retry), 8'(vecs[v].loss)}));
            end
        end

        // No lock at all: two attempts then FAULT, cleared by clear_fault.
        doReset();
        for (int e = 1; e <= 72; e++) begin
            applyStimulus(1'b0, 1'b0, 1'b0);
            if (e == 3)  expectVal("t2_pulse1_end", oPllRst, 1);
            if (e == 4)  expectVal("t2_wait1", oPllRst, 0);
            if (e == 35) expectVal("t2_wait1_last", oPllRst, 0);
            if (e == 36) expectVal("t2_retry1", oRetry, 1);
            if (e == 39) expectVal("t2_pulse2_end", oPllRst, 1);
            if (e == 40) expectVal("t2_wait2", oPllRst, 0);
            if (e == 71) expectVal("t2_prefault", oFault, 0);
        end
        expectVal("t2_fault", oFault, 1);
        expectVal("t2_fault_pll", oPllRst, 1);
        expectVal("t2_fault_retry", oRetry, 2);
        for (int k = 0; k < 5; k++) applyStimulus(1'b0, 1'b1, 1'b0);
        expectVal("t2_fault_held", oFault, 1);
        applyStimulus(1'b0, 1'b0, 1'b1);
        expectVal("t2_clr_fault", oFault, 0);
        expectVal("t2_clr_retry", oRetry, 0);
        expectVal("t2_clr_pll", oPllRst, 1);
        for (int k = 0; k < 3; k++) applyStimulus(1'b0, 1'b0, 1'b0);
        expectVal("t2_newpulse_len", oPllRst, 1);
        applyStimulus(1'b0, 1'b0, 1'b0);
        expectVal("t2_newpulse_end", oPllRst, 0);

        // One-cycle lock glitch after 5 stable cycles restarts qualification.
        doReset();
        for (int k = 0; k < 4; k++) applyStimulus(1'b0, 1'b0, 1'b0);
        for (int k = 0; k < 6; k++) applyStimulus(1'b0, 1'b1, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0);
        cnt = 0;
        do begin
            applyStimulus(1'b0, 1'b1, 1'b0);
            cnt++;
        end while (oSysRst && cnt < 50);
        expectVal("t3_requalify_cycles", cnt, 11);
        expectVal("t3_run", oLockedOk, 1);

        // Lock loss in RUN, then saturation of the loss counter.
        applyStimulus(1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0);
        expectVal("t4_sync_latency", oSysRst, 0);
        applyStimulus(1'b0, 1'b0, 1'b0);
        expectVal("t4_sysrst", oSysRst, 1);
        expectVal("t4_pllrst", oPllRst, 1);
        expectVal("t4_loss1", oLoss, 1);
        for (int n = 0; n < 299; n++) begin
            cnt = 0;
            do begin applyStimulus(1'b0, 1'b1, 1'b0); cnt++; end
            while (!oLockedOk && cnt < 100);
            if (!oLockedOk) expectVal("t4_relock", oLockedOk, 1);
            cnt = 0;
            do begin applyStimulus(1'b0, 1'b0, 1'b0); cnt++; end
            while (oLockedOk && cnt < 10);
            if (oLockedOk) expectVal("t4_drop", oLockedOk, 0);
        end
        expectVal("t4_loss_sat", oLoss, 255);

        // Lock seen exactly on the timeout cycle wins; one cycle later it does not.
        doReset();
        for (int e = 1; e <= 36; e++) applyStimulus(1'b0, e >= 34, 1'b0);
        expectVal("t5_lock_on_timeout_retry", oRetry, 0);
        expectVal("t5_lock_on_timeout_pll", oPllRst, 0);
        applyStimulus(1'b0, 1'b1, 1'b0);
        expectVal("t5_stabilizing", oPllRst, 0);
        doReset();
        for (int e = 1; e <= 36; e++) applyStimulus(1'b0, e >= 35, 1'b0);
        expectVal("t5_late_lock_retry", oRetry, 1);
        expectVal("t5_late_lock_pll", oPllRst, 1);

        // clear_fault ignored in RUN; rst in RUN and in FAULT.
        cnt = 0;
        do begin applyStimulus(1'b0, 1'b1, 1'b0); cnt++; end
        while (!oLockedOk && cnt < 100);
        expectVal("t6_run", oLockedOk, 1);
        applyStimulus(1'b0, 1'b1, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b0);
        cnt = 0;
        do begin applyStimulus(1'b0, 1'b1, 1'b0); cnt++; end
        while (!oLockedOk && cnt < 100);
        expectVal("t6_loss_before_rst", oLoss, 1);
        applyStimulus(1'b0, 1'b1, 1'b1);
        expectVal("t6_clr_in_run_ok", oLockedOk, 1);
        expectVal("t6_clr_in_run_sys", oSysRst, 0);
        applyStimulus(1'b1, 1'b1, 1'b0);
        expectResetVals("t6_rst_in_run");
        for (int e = 1; e <= 72; e++) applyStimulus(1'b0, 1'b0, 1'b0);
        expectVal("t6_fault", oFault, 1);
        applyStimulus(1'b1, 1'b0, 1'b0);
        expectResetVals("t6_rst_in_fault");

        // Randomized lock activity, clear_fault pulses and occasional resets.
        doReset();
        runLeft = 0;
        rndLk = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            if (runLeft == 0) begin
                rndLk   = 1'($urandom_range(0, 1));
                runLeft = $urandom_range(1, 40);
            end
            runLeft--;
            applyStimulus($urandom_range(0, 199) == 0, rndLk, $urandom_range(0, 15) == 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule
